multiword_add_ctrl: RTL and testbench

Sequencer that performs multi-precision addition of two `8*WORDS`-bit operands on a single shared `ripple_carry_adder_8bit`, one 8-bit limb per clock, least-significant limb first. Between limbs it holds the carry in a register, and it retires a registered result. Upstream and downstream connect through valid/ready handshakes. The block sits between operand producers and any consumer that needs wide sums, so the existing 8-bit adder can serve arbitrary widths without replication.

---
 rtl/rca_pkg.sv | 12 +
 rtl/ripple_carry_adder_8bit.sv | 25 ++
 rtl/multiword_add_ctrl.sv | 121 ++++++++++++
 tb/tb_multiword_add_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared limb width and sequencer state encoding
package rca_pkg;

    localparam int LIMB_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ripple_carry_adder_8bit.sv
// rtl/ripple_carry_adder_8bit.sv - shared 8-bit ripple carry limb adder
module ripple_carry_adder_8bit
    import rca_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] sum,
    output logic              cout
);

    // Bit-serial carry chain; the running carry is a block-local variable so
    // there is no feedback through a shared vector.
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < LIMB_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multiword_add_ctrl.sv
// rtl/multiword_add_ctrl.sv - multi-precision adder sequencing one shared 8-bit limb adder
module multiword_add_ctrl
    import rca_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*WORDS-1:0] a,
    input  logic [LIMB_W*WORDS-1:0] b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    busy
);

    localparam int OP_W  = LIMB_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic              carry;
    logic [IDX_W-1:0]  limb_idx;
    int                limb_base;
    logic [LIMB_W-1:0] a_limb;
    logic [LIMB_W-1:0] b_limb;
    logic [LIMB_W-1:0] limb_sum;
    logic              limb_cout;
    logic              last_limb;

    // Select the current limb of the captured operands for the shared adder.
    always_comb begin
        limb_base = LIMB_W * int'(limb_idx);
        a_limb    = a_reg[limb_base +: LIMB_W];
        b_limb    = b_reg[limb_base +: LIMB_W];
        last_limb = (limb_idx == LAST_IDX);
    end

    ripple_carry_adder_8bit u_limb_adder (
        .a    (a_limb),
        .b    (b_limb),
        .cin  (carry),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    // State register; reset wins over every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, walk limbs in RUN, hold result in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_limb) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, carry chaining between limbs and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            limb_idx <= '0;
            sum      <= '0;
            cout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        limb_idx <= '0;
                    end
                end
                RUN: begin
                    sum[limb_base +: LIMB_W] <= limb_sum;
                    carry                    <= limb_cout;
                    limb_idx                 <= limb_idx + 1'b1;
                    if (last_limb) begin
                        cout <= limb_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb/tb_multiword_add_ctrl.sv - scoreboard bench for multiword_add_ctrl
module tb_multiword_add_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;
    bit b2b    = 1'b0;

    logic [W:0] exp_q[$];
    int         acc_q[$];

    multiword_add_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain wide unsigned addition, carry in the top bit.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Monitor: records accepts into the scoreboard and checks every presented result.
    bit prev_valid = 1'b0;
    bit prev_hs    = 1'b0;
    int last_rise  = -1;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            last_rise  = -1;
        end else begin
            if (!b2b) last_rise = -1;
            check("busy_vs_in_ready", {{W{1'b0}}, busy}, {{W{1'b0}}, !in_ready});
            if (prev_hs) check("valid_one_cycle", {{W{1'b0}}, out_valid}, '0);
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(a, b, cin));
                acc_q.push_back(cycle + 1);
            end
            if (out_valid) begin
                check("in_ready_in_done", {{W{1'b0}}, in_ready}, '0);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {{W{1'b0}}, out_valid}, '0);
                end else begin
                    check("result", {cout, sum}, exp_q[0]);
                    if (!prev_valid) begin
                        check("latency", (W+1)'(cycle - acc_q[0]), (W+1)'(WORDS));
                        if (b2b && last_rise >= 0)
                            check("b2b_interval", (W+1)'(cycle - last_rise), (W+1)'(WORDS + 2));
                        last_rise = cycle;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("accept_timeout", {{W{1'b0}}, in_ready}, 1);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        step();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic drain(input bit random_ready);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            if (random_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", (W+1)'(exp_q.size()), '0);
        out_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {{W{1'b0}}, in_ready},  1);
        check({tag, "_out_valid"}, {{W{1'b0}}, out_valid}, 0);
        check({tag, "_busy"},      {{W{1'b0}}, busy},      0);
        check({tag, "_sum_cout"},  {cout, sum},            0);
    endtask

    logic [W:0] held;

    initial begin
        // Reset state, visible right after the first reset edge.
        rst = 1'b1;
        step();
        check_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();

        // Directed vectors with out_ready high.
        do_op(32'h12345678, 32'h9ABCDEF0, 1'b0); drain(0);
        check("basic_sum", {cout, sum}, {1'b0, 32'hACF13568});
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0); drain(0);
        check("carry_all", {cout, sum}, {1'b1, 32'h00000000});
        do_op(32'hAAAAAAAA, 32'h55555555, 1'b1); drain(0);
        check("cin_prop", {cout, sum}, {1'b1, 32'h00000000});
        do_op(32'h0, 32'h0, 1'b0); drain(0);
        check("zero_add", {cout, sum}, '0);

        // Backpressure: hold the result while in_valid pulses are ignored.
        out_ready = 1'b0;
        do_op(W'($urandom), W'($urandom), 1'($urandom));
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("bp_reached_done", {{W{1'b0}}, out_valid}, 1);
        held = {cout, sum};
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            step();
            check("bp_out_valid", {{W{1'b0}}, out_valid}, 1);
            check("bp_in_ready",  {{W{1'b0}}, in_ready},  0);
            check("bp_hold",      {cout, sum},            held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready", {{W{1'b0}}, in_ready}, 1);
        check("bp_release_result",   {cout, sum},           held);
        check("bp_queue_empty",      (W+1)'(exp_q.size()),  0);

        // Reset after two limbs of an all-carry add aborts it.
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
        step();
        step();
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        step();
        rst = 1'b0;
        check_reset_outputs("abort");
        do_op(32'h00000001, 32'h00000001, 1'b0); drain(0);
        check("after_abort", {cout, sum}, {1'b0, 32'h00000002});

        // Randomized operands with random consumer backpressure.
        for (int i = 0; i < 25; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
            drain(1);
        end

        // Back-to-back with in_valid and out_ready tied high.
        b2b = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        drain(0);
        b2b = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1);
    end

endmodule
